// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Result selectors
  localparam logic [3:0] SEL_MUL  = 4'b1010;  // low product word
  localparam logic [3:0] SEL_MULH = 4'b1011;  // high product word (MULH/MULHSU/MULHU)
  localparam logic [3:0] SEL_QUOT = 4'b1100;  // quotient
  localparam logic [3:0] SEL_REM  = 4'b1101;  // remainder

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// One-bit-per-cycle iteration datapath: radix-2 shift-add multiply and
// restoring divide on unsigned magnitudes. Both share one 2*XLEN register:
// for multiply it is {hi, lo} of the product, for divide {remainder, quotient}.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_last,
  output logic [2*XLEN-1:0] o_acc
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     trial;

  // Next-state for one multiply or divide step
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q})
                       : {1'b0, acc_q[2*XLEN-1:XLEN]};
    trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_q};
    if (i_load) begin
      acc_d = {{XLEN{1'b0}}, i_a};
      b_d   = i_b;
      cnt_d = '0;
    end else if (i_step) begin
      cnt_d = cnt_q + 1'b1;
      if (i_div)
        // Borrow means the trial subtraction failed: keep the shifted remainder.
        acc_d = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                            : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Iteration state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_last = (cnt_q == CW'(XLEN - 1));
  assign o_acc  = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: FSM, operand sign handling, special
// divide cases and result register around the muldiv_core iterator.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ctrl_Start_Mul,
  input  logic            i_ctrl_Start_Div,
  input  logic [3:0]      i_ctrl_ALU_Sel,
  input  logic            i_ctrl_Unsigned,
  input  logic            i_ctrl_HSU,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;

  logic            accept, a_sgn_in, b_sgn_in, dz_in, ovf_in, early_in;
  logic [XLEN-1:0] a_mag, b_mag;

  // Unsigned/HSU are folded into the latched operand signs.
  logic [3:0]      sel_q;
  logic            sa_q, sb_q, dz_q;
  logic [XLEN-1:0] rs1_q;

  logic              core_load, core_step, core_div, core_last;
  logic [2*XLEN-1:0] acc, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res, early_res, res_d, result_q;

  assign accept   = (state_q == S_IDLE) & (i_ctrl_Start_Mul | i_ctrl_Start_Div) & ~i_flush & ~i_rst;
  assign a_sgn_in = ~i_ctrl_Unsigned & i_rs1[XLEN-1];
  assign b_sgn_in = (i_ctrl_Start_Mul ? ~i_ctrl_HSU : ~i_ctrl_Unsigned) & i_rs2[XLEN-1];
  assign a_mag    = a_sgn_in ? -i_rs1 : i_rs1;
  assign b_mag    = b_sgn_in ? -i_rs2 : i_rs2;
  assign dz_in    = (i_rs2 == '0);
  assign ovf_in   = ~i_ctrl_Unsigned & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  // A start with both requests high is a multiply, so it never takes the early exit.
  assign early_in = (DIV_EARLY_OUT != 0) & ~i_ctrl_Start_Mul & (dz_in | ovf_in);

  // Capture operation context when a start is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      rs1_q <= '0;
    end else if (accept) begin
      sel_q <= i_ctrl_ALU_Sel;
      sa_q  <= a_sgn_in;
      sb_q  <= b_sgn_in;
      dz_q  <= dz_in & ~i_ctrl_Start_Mul;
      rs1_q <= i_rs1;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (i_ctrl_Start_Mul) state_d = S_MUL;
        else if (early_in)    state_d = S_DONE;
        else                  state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (i_flush)        state_d = S_IDLE;
        else if (core_last) state_d = S_FIX;
      end
      S_FIX:   state_d = i_flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall request, done pulse, core control
  always_comb begin
    o_busy    = ~i_rst & (accept | (((state_q == S_MUL) | (state_q == S_DIV) |
                                     (state_q == S_FIX)) & ~i_flush));
    o_done    = (state_q == S_DONE);
    core_load = accept;
    core_step = ((state_q == S_MUL) | (state_q == S_DIV)) & ~i_flush;
    core_div  = (state_q == S_DIV);
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (core_load),
    .i_step (core_step),
    .i_div  (core_div),
    .i_a    (a_mag),
    .i_b    (b_mag),
    .o_last (core_last),
    .o_acc  (acc)
  );

  // Sign fix-up during FIX and special-case result selection
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc : acc;
    quot_s = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    unique case (sel_q)
      SEL_MULH: fix_res = prod_s[2*XLEN-1:XLEN];
      SEL_QUOT: fix_res = dz_q ? '1 : quot_s;
      SEL_REM:  fix_res = dz_q ? rs1_q : rem_s;
      default:  fix_res = prod_s[XLEN-1:0];
    endcase
    if (i_ctrl_ALU_Sel == SEL_REM) early_res = dz_in ? i_rs1 : '0;
    else                           early_res = dz_in ? '1 : MIN_NEG;
    res_d = (state_q == S_IDLE) ? early_res : fix_res;
  end

  // Result register, loaded on entry to DONE and held until the next one
  always_ff @(posedge i_clk) begin
    if (i_rst)                  result_q <= '0;
    else if (state_d == S_DONE) result_q <= res_d;
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected result and cycle,
// a monitor pops and compares on every o_done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_mul = 1'b0, start_div = 1'b0;
  logic [3:0]  sel = 4'b0;
  logic        uns = 1'b0, hsu = 1'b0, flush = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sbq[$];

  muldiv_seq #(.XLEN(32), .DIV_EARLY_OUT(1)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_ctrl_Start_Mul (start_mul),
    .i_ctrl_Start_Div (start_div),
    .i_ctrl_ALU_Sel   (sel),
    .i_ctrl_Unsigned  (uns),
    .i_ctrl_HSU       (hsu),
    .i_rs1            (rs1),
    .i_rs2            (rs2),
    .i_flush          (flush),
    .o_busy           (busy),
    .o_done           (done),
    .o_result         (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit m, input bit d, input logic [3:0] s, input bit u, input bit h,
                       input logic [31:0] a, input logic [31:0] b);
    start_mul = m; start_div = d; sel = s; uns = u; hsu = h; rs1 = a; rs2 = b;
  endtask

  task automatic expect_res(input logic [31:0] r, input int lat);
    exp_t e;
    e.res = r;
    e.at  = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic op(input bit m, input bit d, input logic [3:0] s, input bit u, input bit h,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input int lat);
    @(negedge clk);
    drive(m, d, s, u, h, a, b);
    expect_res(r, lat);
    #1 check("busy_on_accept", busy, 1);
    @(negedge clk);
    start_mul = 0; start_div = 0;
    repeat (lat) @(negedge clk);
  endtask

  // Monitor: every o_done must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.at));
          check("result", result, e.res);
        end
      end
    end
  end

  initial begin
    int nbusy;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    rst = 0;

    // MULH -1 * 2 with busy window N..N+33
    @(negedge clk);
    drive(1, 0, SEL_MULH, 0, 0, 32'hFFFF_FFFF, 32'h2);
    expect_res(32'hFFFF_FFFF, 34);
    nbusy = 0;
    for (int k = 0; k < 34; k++) begin
      #1 if (busy) nbusy++;
      @(negedge clk);
      start_mul = 0;
    end
    #1;
    check("mulh_busy_cycles", 64'(nbusy), 34);
    check("mulh_busy_low_at_done", busy, 0);
    @(negedge clk);

    op(1, 0, SEL_MULH, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34); // MULHU
    op(1, 0, SEL_MUL,  1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34); // MUL low
    op(1, 0, SEL_MULH, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34); // MULHSU
    op(0, 1, SEL_QUOT, 0, 0, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);         // DIV -7/2
    op(0, 1, SEL_REM,  0, 0, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34);         // REM -7/2
    op(0, 1, SEL_QUOT, 1, 0, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);                  // DIVU /0
    op(0, 1, SEL_REM,  0, 0, 32'h5, 32'h0, 32'h5, 1);                          // REM /0
    op(0, 1, SEL_QUOT, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);  // DIV ovf
    op(0, 1, SEL_REM,  0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);          // REM ovf
    op(0, 1, SEL_REM,  1, 0, 32'd100, 32'd7, 32'd2, 34);                       // REMU

    // Flush a DIV at N+10, restart at N+11
    @(negedge clk);
    drive(0, 1, SEL_QUOT, 0, 0, 32'd100, 32'd7);
    @(negedge clk);
    start_div = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    #1 check("flush_busy_low", busy, 0);
    @(negedge clk);
    flush = 0;
    drive(0, 1, SEL_QUOT, 1, 0, 32'd100, 32'd7);
    expect_res(32'd14, 34);
    #1;
    check("flush_restart_busy", busy, 1);
    check("flush_result_kept", result, 32'd2);
    @(negedge clk);
    start_div = 0;
    repeat (34) @(negedge clk);

    // Reset at N+5 of a MUL, start held high during reset
    @(negedge clk);
    drive(1, 0, SEL_MUL, 0, 0, 32'd7, 32'd9);
    @(negedge clk);
    start_mul = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    start_mul = 1;
    #1 check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    start_mul = 0;
    #1;
    check("rst_mid_busy_after", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    repeat (40) @(negedge clk);

    // Both starts: multiply wins
    op(1, 1, SEL_MUL, 0, 0, 32'd3, 32'd5, 32'd15, 34);

    @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
